// File: rtl/deck_dealer.sv
// deck_dealer: deals nine distinct playing cards into fixed output slots.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   draw_card        level request, held high until the deal completes
//   dealt_cards      nine 6-bit cards {suit[1:0], rank[3:0]}; card i at [6i+5:6i]
//                    (0,1 player; 2,3 dealer; 4..8 community)
//   all_cards_dealt  high once all nine slots hold valid cards
//   busy             high while dealing
//
// Configuration:
//   DEALER_FIXED_DECK_EN  when defined, candidates come from a deterministic
//                         sequence {2'b00, counter+2} instead of the LFSR.
module deck_dealer (
  input  logic        clk,
  input  logic        reset,
  input  logic        draw_card,
  output logic [53:0] dealt_cards,
  output logic        all_cards_dealt,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StDeal = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [15:0] LfsrSeed = 16'hACE1;

  state_e          state_q;
  logic [15:0]     lfsr_q;
  logic [3:0]      cnt_q;
  logic [51:0]     mask_q;
  logic [8:0][5:0] cards_q;
  logic            all_dealt_q;
  logic            busy_q;

  logic       lfsr_fb;
  logic [5:0] cand;
  logic [1:0] cand_suit;
  logic [3:0] cand_rank;
  logic [5:0] cand_idx;
  logic       rank_ok;
  logic       accept;

  // Taps 16,14,13,11 in right-shift form: bit 0 is the oldest stage.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

`ifdef DEALER_FIXED_DECK_EN
  assign cand = {2'b00, cnt_q + 4'd2};
`else
  assign cand = lfsr_q[5:0];
`endif

  assign cand_suit = cand[5:4];
  assign cand_rank = cand[3:0];
  assign rank_ok   = (cand_rank >= 4'd2) && (cand_rank <= 4'd14);
  assign cand_idx  = {4'b0000, cand_suit} * 6'd13 + {2'b00, cand_rank} - 6'd2;
  // rank_ok guards the mask lookup so out-of-range indices are never used.
  assign accept    = rank_ok && !mask_q[cand_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      lfsr_q      <= LfsrSeed;
      cnt_q       <= 4'd0;
      mask_q      <= '0;
      cards_q     <= '0;
      all_dealt_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
      case (state_q)
        StIdle: begin
          if (draw_card) begin
            cnt_q       <= 4'd0;
            mask_q      <= '0;
            cards_q     <= '0;
            all_dealt_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= StDeal;
          end
        end
        StDeal: begin
          if (!draw_card) begin
            // Abort: discard the partial hand.
            cnt_q       <= 4'd0;
            mask_q      <= '0;
            cards_q     <= '0;
            all_dealt_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end else if (accept) begin
            cards_q[cnt_q]   <= cand;
            mask_q[cand_idx] <= 1'b1;
            cnt_q            <= cnt_q + 4'd1;
            if (cnt_q == 4'd8) begin
              all_dealt_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= StDone;
            end
          end
        end
        StDone: begin
          // Cards and flag stay valid into IDLE so the consumer can latch late.
          if (!draw_card) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          cnt_q       <= 4'd0;
          mask_q      <= '0;
          cards_q     <= '0;
          all_dealt_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign dealt_cards     = cards_q;
  assign all_cards_dealt = all_dealt_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_deck_dealer.sv
// Testbench for deck_dealer: table-driven phases, a cycle-level reference model,
// hand-written abort / hold / mid-deal reset sequences and per-deal card checks.
module tb_deck_dealer;

  logic        clk;
  logic        reset;
  logic        draw_card;
  logic [53:0] dealt_cards;
  logic        all_cards_dealt;
  logic        busy;

  deck_dealer dut (
    .clk             (clk),
    .reset           (reset),
    .draw_card       (draw_card),
    .dealt_cards     (dealt_cards),
    .all_cards_dealt (all_cards_dealt),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model (0 idle, 1 deal, 2 done).
  int          m_state;
  logic [15:0] m_lfsr;
  int          m_cnt;
  logic [51:0] m_mask;
  logic [53:0] m_cards;
  logic        m_done;
  logic        m_busy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_state = 0; m_lfsr = 16'hACE1; m_cnt = 0; m_mask = '0; m_cards = '0;
    m_done = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [15:0] nl;
    logic [5:0]  c;
    int          rank, suit, idx;
    nl = {^(m_lfsr & 16'h002D), m_lfsr[15:1]};
`ifdef DEALER_FIXED_DECK_EN
    c = 6'(m_cnt + 2);
`else
    c = m_lfsr[5:0];
`endif
    rank = int'(c[3:0]);
    suit = int'(c[5:4]);
    idx  = suit * 13 + rank - 2;
    if (m_state == 0) begin
      if (draw_card) begin
        m_state = 1; m_cnt = 0; m_mask = '0; m_cards = '0; m_done = 0; m_busy = 1;
      end
    end else if (m_state == 1) begin
      if (!draw_card) begin
        m_state = 0; m_cnt = 0; m_mask = '0; m_cards = '0; m_done = 0; m_busy = 0;
      end else if (rank >= 2 && rank <= 14 && !m_mask[idx]) begin
        m_cards[6*m_cnt +: 6] = c;
        m_mask[idx] = 1'b1;
        m_cnt++;
        if (m_cnt == 9) begin
          m_state = 2; m_done = 1; m_busy = 0;
        end
      end
    end else begin
      if (!draw_card) m_state = 0;
    end
    m_lfsr = nl;
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    @(negedge clk);
    check("busy", 64'(busy), 64'(m_busy));
    check("all_cards_dealt", 64'(all_cards_dealt), 64'(m_done));
    check("dealt_cards", 64'(dealt_cards), 64'(m_cards));
  endtask

  task automatic check_deal(input logic [53:0] cards);
    bit range_ok = 1'b1;
    bit distinct = 1'b1;
    logic [5:0] a, b;
    for (int i = 0; i < 9; i++) begin
      a = cards[6*i +: 6];
      if (a[3:0] < 4'd2 || a[3:0] > 4'd14) range_ok = 1'b0;
      for (int j = i + 1; j < 9; j++) begin
        b = cards[6*j +: 6];
        if (a == b) distinct = 1'b0;
      end
    end
    check("card_rank_range", 64'(range_ok), 64'd1);
    check("cards_distinct", 64'(distinct), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!all_cards_dealt && n < 2000) begin
      tick();
      n++;
    end
    check(name, 64'(all_cards_dealt), 64'd1);
  endtask

  typedef struct {
    bit draw;
    int cycles;
    bit exp_busy;
    bit exp_done;
    bit exp_zero;
  } phase_t;

  phase_t phases[7];
  logic [53:0] fixed_exp;
  logic [53:0] held;

  initial begin
    phases[0] = '{draw: 0, cycles: 5,    exp_busy: 0, exp_done: 0, exp_zero: 1};
    phases[1] = '{draw: 1, cycles: 1,    exp_busy: 1, exp_done: 0, exp_zero: 1};
    phases[2] = '{draw: 1, cycles: 1999, exp_busy: 0, exp_done: 1, exp_zero: 0};
    phases[3] = '{draw: 0, cycles: 100,  exp_busy: 0, exp_done: 1, exp_zero: 0};
    phases[4] = '{draw: 1, cycles: 1,    exp_busy: 1, exp_done: 0, exp_zero: 1};
    phases[5] = '{draw: 0, cycles: 1,    exp_busy: 0, exp_done: 0, exp_zero: 1};
    phases[6] = '{draw: 0, cycles: 10,   exp_busy: 0, exp_done: 0, exp_zero: 1};

    for (int i = 0; i < 9; i++) fixed_exp[6*i +: 6] = 6'(8'h02 + i);

    draw_card = 1'b0;
    reset     = 1'b1;
    model_reset();
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(all_cards_dealt), 64'd0);
    check("reset_cards", 64'(dealt_cards), 64'd0);
    check("reset_lfsr", 64'(dut.lfsr_q), 64'hACE1);
    tick();
    tick();
    reset = 1'b0;

    for (int p = 0; p < 7; p++) begin
      draw_card = phases[p].draw;
      for (int c = 0; c < phases[p].cycles; c++) begin
        if (p == 3) held = dealt_cards;
        if (!(p == 2 && all_cards_dealt)) tick();
        if (p == 3) check("hold_cards", 64'(dealt_cards), 64'(held));
      end
      check("phase_busy", 64'(busy), 64'(phases[p].exp_busy));
      check("phase_done", 64'(all_cards_dealt), 64'(phases[p].exp_done));
      check("phase_cards_zero", 64'(dealt_cards == '0), 64'(phases[p].exp_zero));
      if (p == 2) check_deal(dealt_cards);
    end

`ifdef DEALER_FIXED_DECK_EN
    // Exact timing: start edge N, busy through N+8, done at N+9.
    draw_card = 1'b1;
    tick();
    check("fixed_busy_start", 64'(busy), 64'd1);
    for (int k = 1; k < 9; k++) begin
      tick();
      check("fixed_busy_mid", 64'(busy), 64'd1);
      check("fixed_done_mid", 64'(all_cards_dealt), 64'd0);
    end
    tick();
    check("fixed_done_n9", 64'(all_cards_dealt), 64'd1);
    check("fixed_cards", 64'(dealt_cards), 64'(fixed_exp));
    draw_card = 1'b0;
    tick();
`endif

    // Many back-to-back deals.
    for (int d = 0; d < 200; d++) begin
      draw_card = 1'b1;
      tick();
      wait_done("deal_timeout");
      check_deal(dealt_cards);
`ifdef DEALER_FIXED_DECK_EN
      check("fixed_deal_cards", 64'(dealt_cards), 64'(fixed_exp));
`endif
      draw_card = 1'b0;
      tick();
      check("drop_to_idle_done", 64'(all_cards_dealt), 64'd1);
    end

    // Abort after four accepts.
    draw_card = 1'b1;
    begin
      int n = 0;
      while (m_cnt != 4 && n < 2000) begin tick(); n++; end
      check("abort_reach4", 64'(m_cnt), 64'd4);
    end
    draw_card = 1'b0;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(all_cards_dealt), 64'd0);
    check("abort_cards", 64'(dealt_cards), 64'd0);
    draw_card = 1'b1;
    tick();
    wait_done("abort_redeal_timeout");
    check_deal(dealt_cards);
`ifdef DEALER_FIXED_DECK_EN
    check("abort_redeal_cards", 64'(dealt_cards), 64'(fixed_exp));
`endif
    draw_card = 1'b0;
    tick();

    // Reset while five cards are in.
    draw_card = 1'b1;
    begin
      int n = 0;
      while (m_cnt != 5 && n < 2000) begin tick(); n++; end
      check("reset_reach5", 64'(m_cnt), 64'd5);
    end
    #2 reset = 1'b1;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(all_cards_dealt), 64'd0);
    check("midreset_cards", 64'(dealt_cards), 64'd0);
    check("midreset_lfsr", 64'(dut.lfsr_q), 64'hACE1);
    model_reset();
    draw_card = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check("post_reset_idle", 64'(busy), 64'd0);
    draw_card = 1'b1;
    tick();
    check("post_reset_start", 64'(busy), 64'd1);
    wait_done("post_reset_deal_timeout");
    check_deal(dealt_cards);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
